cp0_exc_ctrl: RTL

- Coprocessor-0 exception/interrupt controller in the M stage of the P8 pipelined MIPS core.
- It is the responder side of the PC-redirect interface. It decides when to raise Req, which drives the PC to handler 0x0000_4180 and flushes the pipe. It latches EPC/Cause/SR, serves mfc0/mtc0, and supplies EPC for eret.
- It sits between the M-stage pipeline register, the bridge (HWInt lines) and the PC/NPC logic.

---
 rtl/cp0_exc_ctrl_if.sv | 24 ++
 rtl/cp0_exc_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl_if.sv
// Bus between the M-stage pipeline/PC logic (master) and the CP0 exception controller (slave).
interface cp0_exc_ctrl_if;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    modport master (
        output A, DIn, We, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  Req, EPCOut, DOut
    );

    modport slave (
        input  A, DIn, We, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output Req, EPCOut, DOut
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: raises Req, latches EPC/Cause/SR, serves mfc0/mtc0.
// Define CP0_EXC_COUNT_EN to add a wrapping Req counter readable as CP0 register 9.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID = 32'h2021_0008
) (
    input  logic            clk,
    input  logic            reset,
    cp0_exc_ctrl_if.slave   bus
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] victim_pc;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic        unused_vpc_low;

    assign int_req = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (bus.ExcCodeIn != 5'd0) & ~sr_exl;
    // Gated so an exception code seen while reset is held cannot redirect the PC.
    assign req     = (int_req | exc_req) & ~reset;

    assign victim_pc      = {bus.VPC[31:2], 2'b00};
    assign epc_next       = bus.BDIn ? (victim_pc - 32'd4) : victim_pc;
    assign unused_vpc_low = ^bus.VPC[1:0];

    assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b00};

    // A request outranks mtc0 and eret; eret is applied after an SR write so EXL ends clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= bus.HWInt;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bus.BDIn;
                cause_exc <= int_req ? 5'd0 : bus.ExcCodeIn;
                epc       <= epc_next;
            end else begin
                if (bus.We && bus.A == 5'd12) begin
                    sr_im  <= bus.DIn[15:10];
                    sr_exl <= bus.DIn[1];
                    sr_ie  <= bus.DIn[0];
                end
                if (bus.We && bus.A == 5'd14) begin
                    epc <= {bus.DIn[31:2], 2'b00};
                end
                if (bus.EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

`ifdef CP0_EXC_COUNT_EN
    logic [31:0] exc_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_count <= 32'd0;
        end else if (req) begin
            exc_count <= exc_count + 32'd1;
        end
    end
`endif

    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A)
            5'd12:   bus.DOut = sr_word;
            5'd13:   bus.DOut = cause_word;
            5'd14:   bus.DOut = epc;
            5'd15:   bus.DOut = PRID;
`ifdef CP0_EXC_COUNT_EN
            5'd9:    bus.DOut = exc_count;
`endif
            default: bus.DOut = 32'd0;
        endcase
    end

    assign bus.Req    = req;
    assign bus.EPCOut = epc;

endmodule
